// File: rtl/regfile_verify_pkg.sv
// Package for the regfile run-and-check controller.
//   - verify_state_t : controller state encoding (IDLE/RUN/SCAN/DONE)
//   - DEF_*          : default parameter values shared by every file
//   - sig_update     : write-signature step, rotate-left-by-one then XOR with
//                      the written data and register index
// Optional feature macro used elsewhere: WRITE_SIGNATURE_EN.
package regfile_verify_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    SCAN = 2'd2,
    DONE = 2'd3
  } verify_state_t;

  localparam int DEF_DATA_W         = 32;
  localparam int DEF_NUM_REGS       = 32;
  localparam int DEF_ADDR_W         = 5;
  localparam int DEF_CYCLE_W        = 10;
  localparam int DEF_DEFAULT_CYCLES = 255;

  // Widest signature the helper handles; callers zero-extend narrower values.
  localparam int SIG_MAX_W = 64;

  // Rotation wraps at 'width' bits, so the upper bits of the inputs must be 0.
  function automatic logic [SIG_MAX_W-1:0] sig_update(
    input logic [SIG_MAX_W-1:0] sig,
    input logic [SIG_MAX_W-1:0] data,
    input logic [SIG_MAX_W-1:0] rd,
    input int unsigned          width
  );
    logic [SIG_MAX_W-1:0] mask;
    logic [SIG_MAX_W-1:0] rot;
    mask = (width >= SIG_MAX_W) ? '1 : ((SIG_MAX_W'(1) << width) - SIG_MAX_W'(1));
    rot  = ((sig << 1) | (sig >> (width - 1))) & mask;
    return (rot ^ data ^ rd) & mask;
  endfunction

endpackage

// File: rtl/regfile_verify_unit_if.sv
// Bus bundle between the run-and-check controller and its environment
// (processor write port, regfile read port A, expected-value memory, log and
// mismatch sinks, status).
//   master : the controller side (regfile_verify_unit)
//   slave  : the wrapper / testbench side
// With WRITE_SIGNATURE_EN defined the bundle also carries write_sig.
interface regfile_verify_unit_if #(
  parameter int DATA_W  = 32,
  parameter int ADDR_W  = 5,
  parameter int CYCLE_W = 10
);

  logic               start;
  logic [CYCLE_W-1:0] num_cycles;
  logic               rwe;
  logic [ADDR_W-1:0]  rd;
  logic [DATA_W-1:0]  rData;
  logic [DATA_W-1:0]  regA;
  logic               test_mode;
  logic [ADDR_W-1:0]  rs_test;
  logic [ADDR_W-1:0]  exp_addr;
  logic [DATA_W-1:0]  exp_data;
  logic               log_valid;
  logic [CYCLE_W-1:0] log_cycle;
  logic [ADDR_W-1:0]  log_reg;
  logic [DATA_W-1:0]  log_data;
  logic               mis_valid;
  logic [ADDR_W-1:0]  mis_reg;
  logic [DATA_W-1:0]  mis_exp;
  logic [DATA_W-1:0]  mis_act;
  logic               busy;
  logic               done;
  logic               pass;
  logic [ADDR_W:0]    error_count;
`ifdef WRITE_SIGNATURE_EN
  logic [DATA_W-1:0]  write_sig;
`endif

  modport master (
    input  start, num_cycles, rwe, rd, rData, regA, exp_data,
    output test_mode, rs_test, exp_addr,
    output log_valid, log_cycle, log_reg, log_data,
    output mis_valid, mis_reg, mis_exp, mis_act,
    output busy, done, pass, error_count
`ifdef WRITE_SIGNATURE_EN
    , output write_sig
`endif
  );

  modport slave (
    output start, num_cycles, rwe, rd, rData, regA, exp_data,
    input  test_mode, rs_test, exp_addr,
    input  log_valid, log_cycle, log_reg, log_data,
    input  mis_valid, mis_reg, mis_exp, mis_act,
    input  busy, done, pass, error_count
`ifdef WRITE_SIGNATURE_EN
    , input write_sig
`endif
  );

endinterface

// File: rtl/verify_scan_pipe.sv
// Two-stage register scan used while the controller is in SCAN.
//   Issue stage   : drives test_mode/rs_test/exp_addr for idx 0..NUM_REGS-1
//                   and captures regA at the end of the cycle.
//   Compare stage : next cycle, compares the captured value with exp_data
//                   (synchronous memory, so it lines up with the capture).
// Ports:
//   clock, reset      system clock, synchronous active-high reset
//   clear             start accepted: restart index and error count
//   scan_en           controller is in SCAN
//   regA, exp_data    read-port-A data and expected-memory data
//   test_mode, rs_test, exp_addr   issue-stage outputs
//   mis_valid/reg/exp/act          one-cycle mismatch strobe and payload
//   error_count       saturating mismatch count
//   scan_last         final register is being compared this cycle
module verify_scan_pipe import regfile_verify_pkg::*; #(
  parameter int DATA_W   = DEF_DATA_W,
  parameter int NUM_REGS = DEF_NUM_REGS,
  parameter int ADDR_W   = DEF_ADDR_W
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              clear,
  input  logic              scan_en,
  input  logic [DATA_W-1:0] regA,
  input  logic [DATA_W-1:0] exp_data,
  output logic              test_mode,
  output logic [ADDR_W-1:0] rs_test,
  output logic [ADDR_W-1:0] exp_addr,
  output logic              mis_valid,
  output logic [ADDR_W-1:0] mis_reg,
  output logic [DATA_W-1:0] mis_exp,
  output logic [DATA_W-1:0] mis_act,
  output logic [ADDR_W:0]   error_count,
  output logic              scan_last
);

  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(NUM_REGS - 1);

  logic [ADDR_W-1:0] idx;
  logic              issue_done;
  logic              issue;
  logic              cmp_valid;
  logic [ADDR_W-1:0] cmp_idx;
  logic [DATA_W-1:0] act_q;
  logic              mismatch;
  logic [ADDR_W:0]   err_q;

  // Issue runs once per SCAN; issue_done keeps the final compare cycle
  // from issuing again and lets test_mode drop after the last register.
  assign issue = scan_en && !issue_done;

  always_ff @(posedge clock) begin
    if (reset || clear) begin
      idx        <= '0;
      issue_done <= 1'b0;
    end else if (issue) begin
      if (idx == LAST_IDX) begin
        issue_done <= 1'b1;
      end else begin
        idx <= idx + ADDR_W'(1);
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset || clear) begin
      cmp_valid <= 1'b0;
      cmp_idx   <= '0;
      act_q     <= '0;
    end else begin
      cmp_valid <= issue;
      if (issue) begin
        cmp_idx <= idx;
        act_q   <= regA;
      end
    end
  end

  assign mismatch  = cmp_valid && (act_q != exp_data);
  assign scan_last = cmp_valid && (cmp_idx == LAST_IDX);

  always_ff @(posedge clock) begin
    if (reset || clear) begin
      err_q <= '0;
    end else if (mismatch && (err_q != '1)) begin
      err_q <= err_q + (ADDR_W+1)'(1);
    end
  end

  // Payloads are zeroed outside a strobe so idle outputs read as 0.
  assign test_mode   = issue;
  assign rs_test     = issue ? idx : '0;
  assign exp_addr    = issue ? idx : '0;
  assign mis_valid   = mismatch;
  assign mis_reg     = mismatch ? cmp_idx  : '0;
  assign mis_exp     = mismatch ? exp_data : '0;
  assign mis_act     = mismatch ? act_q    : '0;
  assign error_count = err_q;

endmodule

// File: rtl/regfile_verify_unit.sv
// Run-and-check controller for the processor regfile.
// Runs the CPU for a programmed number of cycles while logging every non-r0
// register write with its cycle stamp, then hijacks regfile read port A and
// compares every register against an expected-value memory.
// Ports:
//   clock  system clock (posedge)
//   reset  synchronous, active-high; aborts any run back to IDLE
//   bus    regfile_verify_unit_if.master: start/num_cycles, processor write
//          port (rwe/rd/rData), read port A (regA/test_mode/rs_test),
//          expected memory (exp_addr/exp_data), log_*, mis_*, busy/done/
//          pass/error_count
// Optional macro WRITE_SIGNATURE_EN adds bus.write_sig, a rolling signature
// of every logged write, cleared on start and stable in DONE.
module regfile_verify_unit import regfile_verify_pkg::*; #(
  parameter int DATA_W         = DEF_DATA_W,
  parameter int NUM_REGS       = DEF_NUM_REGS,
  parameter int ADDR_W         = DEF_ADDR_W,
  parameter int CYCLE_W        = DEF_CYCLE_W,
  parameter int DEFAULT_CYCLES = DEF_DEFAULT_CYCLES
) (
  input  logic                  clock,
  input  logic                  reset,
  regfile_verify_unit_if.master bus
);

  localparam logic [CYCLE_W-1:0] DEF_LEN = CYCLE_W'(DEFAULT_CYCLES);

  verify_state_t      state;
  verify_state_t      state_next;
  logic               start_accept;
  logic               run_last;
  logic               scan_last;
  logic [CYCLE_W-1:0] cyc;
  logic [CYCLE_W-1:0] len;
  logic               log_hit;
  logic               busy;
  logic               done;
  logic               pass;
  logic [ADDR_W:0]    error_count;

  assign start_accept = bus.start && ((state == IDLE) || (state == DONE));
  assign run_last     = (state == RUN) && (cyc == (len - CYCLE_W'(1)));

  always_ff @(posedge clock) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE, DONE: if (bus.start) state_next = RUN;
      RUN:        if (run_last)  state_next = SCAN;
      SCAN:       if (scan_last) state_next = DONE;
      default:    state_next = IDLE;
    endcase
  end

  always_comb begin
    busy = 1'b0;
    done = 1'b0;
    pass = 1'b0;
    case (state)
      RUN, SCAN: busy = 1'b1;
      DONE: begin
        done = 1'b1;
        pass = (error_count == '0);
      end
      default: ;
    endcase
  end

  // A zero run length selects DEFAULT_CYCLES; the run lasts exactly len cycles.
  always_ff @(posedge clock) begin
    if (reset) begin
      cyc <= '0;
      len <= '0;
    end else if (start_accept) begin
      cyc <= '0;
      len <= (bus.num_cycles == '0) ? DEF_LEN : bus.num_cycles;
    end else if (state == RUN) begin
      cyc <= cyc + CYCLE_W'(1);
    end
  end

  // Writes to r0 are architecturally discarded, so they are not logged.
  assign log_hit = (state == RUN) && bus.rwe && (bus.rd != '0);

  always_ff @(posedge clock) begin
    if (reset) begin
      bus.log_valid <= 1'b0;
      bus.log_cycle <= '0;
      bus.log_reg   <= '0;
      bus.log_data  <= '0;
    end else begin
      bus.log_valid <= log_hit;
      if (log_hit) begin
        bus.log_cycle <= cyc;
        bus.log_reg   <= bus.rd;
        bus.log_data  <= bus.rData;
      end
    end
  end

`ifdef WRITE_SIGNATURE_EN
  logic [DATA_W-1:0] sig_q;

  always_ff @(posedge clock) begin
    if (reset || start_accept) begin
      sig_q <= '0;
    end else if (log_hit) begin
      sig_q <= DATA_W'(sig_update(SIG_MAX_W'(sig_q), SIG_MAX_W'(bus.rData),
                                  SIG_MAX_W'(bus.rd), DATA_W));
    end
  end

  assign bus.write_sig = sig_q;
`endif

  verify_scan_pipe #(
    .DATA_W   (DATA_W),
    .NUM_REGS (NUM_REGS),
    .ADDR_W   (ADDR_W)
  ) u_scan (
    .clock       (clock),
    .reset       (reset),
    .clear       (start_accept),
    .scan_en     (state == SCAN),
    .regA        (bus.regA),
    .exp_data    (bus.exp_data),
    .test_mode   (bus.test_mode),
    .rs_test     (bus.rs_test),
    .exp_addr    (bus.exp_addr),
    .mis_valid   (bus.mis_valid),
    .mis_reg     (bus.mis_reg),
    .mis_exp     (bus.mis_exp),
    .mis_act     (bus.mis_act),
    .error_count (error_count),
    .scan_last   (scan_last)
  );

  assign bus.busy        = busy;
  assign bus.done        = done;
  assign bus.pass        = pass;
  assign bus.error_count = error_count;

endmodule
